// File: rtl/nn_fp_pkg.sv
// Shared FP32 definitions for the network's classifier and pooling stages.
// Provides the field-width constants, FP32 field-extraction helpers and
// the scan FSM state encoding used by fp_argmax.
package nn_fp_pkg;

    localparam int unsigned FP_W   = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned MAG_W  = EXP_W + MANT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[FP_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[FP_W-2 -: EXP_W];
    endfunction

    function automatic logic [MANT_W-1:0] fp_mant(input logic [FP_W-1:0] x);
        return x[MANT_W-1:0];
    endfunction

    // {exp,mant} as one unsigned magnitude; ordering matches |x| for non-NaN
    function automatic logic [MAG_W-1:0] fp_mag(input logic [FP_W-1:0] x);
        return x[MAG_W-1:0];
    endfunction

    function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
        return (fp_exp(x) == {EXP_W{1'b1}}) && (fp_mant(x) != '0);
    endfunction

endpackage

// File: rtl/fp_gt.sv
// Combinational FP32 "a strictly greater than b" comparator.
// Ports:
//   a, b  : FP32 operands (bit patterns)
//   gt_c  : 1 when a > b; NaN operands never win, but any non-NaN a beats a
//           NaN b; +0 and -0 compare equal; denormals compare by pattern.
module fp_gt
    import nn_fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            gt_c
);

    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;
    logic             sign_a;
    logic             sign_b;
    logic             nan_a;
    logic             nan_b;

    always_comb begin
        mag_a  = fp_mag(a);
        mag_b  = fp_mag(b);
        sign_a = fp_sign(a);
        sign_b = fp_sign(b);
        nan_a  = fp_is_nan(a);
        nan_b  = fp_is_nan(b);
    end

    // Signed-magnitude ordering; zero check precedes the sign check so that
    // -0 vs +0 is a tie rather than a sign win.
    always_comb begin
        gt_c = 1'b0;
        if (nan_a) begin
            gt_c = 1'b0;
        end else if (nan_b) begin
            gt_c = 1'b1;
        end else if ((mag_a == '0) && (mag_b == '0)) begin
            gt_c = 1'b0;
        end else if (sign_a != sign_b) begin
            gt_c = sign_b;
        end else if (!sign_a) begin
            gt_c = (mag_a > mag_b);
        end else begin
            gt_c = (mag_a < mag_b);
        end
    end

endmodule

// File: rtl/fp_argmax.sv
// Sequential argmax over N FP32 lanes, one lane compared per clock.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake for the packed vector
//   in_vector         : N*32 bits, lane 0 at the MSB end
//   out_valid/out_ready : result handshake
//   out_index         : winning lane (lowest index on ties)
//   out_value         : winning lane's FP32 pattern
//   out_nan           : every lane was NaN
module fp_argmax
    import nn_fp_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*FP_W-1:0]  in_vector,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic [FP_W-1:0]    out_value,
    output logic               out_nan
);

    localparam int unsigned       VEC_W    = N * FP_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   cnt;
    logic [VEC_W-1:0]   vec_q;
    logic [IDX_W-1:0]   best_idx;
    logic [FP_W-1:0]    best_val;
    logic               all_nan;

    logic [FP_W-1:0]    lanes [N];
    logic [FP_W-1:0]    cur_val;
    logic [FP_W-1:0]    lane0_in;
    logic               cur_gt;

    logic               accept;
    logic               scan_step;
    logic               present;
    logic               release_out;

    // Unpack the latched vector into lanes; lane 0 sits at the MSB end
    always_comb begin
        for (int k = 0; k < N; k++) begin
            lanes[k] = vec_q[(N - k) * FP_W - 1 -: FP_W];
        end
        cur_val  = lanes[cnt];
        lane0_in = in_vector[VEC_W-1 -: FP_W];
    end

    fp_gt u_gt (
        .a    (cur_val),
        .b    (best_val),
        .gt_c (cur_gt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid && in_ready)    next_state = SCAN;
            SCAN: if (cnt == LAST_IDX)         next_state = DONE;
            DONE: if (out_valid && out_ready)  next_state = IDLE;
            default:                           next_state = IDLE;
        endcase
    end

    // Per-state control strobes. The first DONE cycle publishes the result,
    // which gives the N-cycle latency from acceptance to out_valid.
    always_comb begin
        accept      = 1'b0;
        scan_step   = 1'b0;
        present     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: accept    = in_valid && in_ready;
            SCAN: scan_step = 1'b1;
            DONE: begin
                present     = !out_valid;
                release_out = out_valid && out_ready;
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            vec_q     <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            all_nan   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_index <= '0;
            out_value <= '0;
            out_nan   <= 1'b0;
        end else begin
            in_ready <= (next_state == IDLE);

            if (accept) begin
                vec_q    <= in_vector;
                best_idx <= '0;
                best_val <= lane0_in;
                all_nan  <= fp_is_nan(lane0_in);
                cnt      <= IDX_W'(1);
            end

            if (scan_step) begin
                if (cur_gt) begin
                    best_idx <= cnt;
                    best_val <= cur_val;
                end
                all_nan <= all_nan & fp_is_nan(cur_val);
                cnt     <= (cnt == LAST_IDX) ? '0 : cnt + IDX_W'(1);
            end

            if (present) begin
                out_valid <= 1'b1;
                out_index <= best_idx;
                out_value <= best_val;
                out_nan   <= all_nan;
            end

            if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_argmax.sv
// Directed self-checking bench for fp_argmax (N=4).
module tb_fp_argmax;

    localparam int unsigned N     = 4;
    localparam int unsigned IDX_W = 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N*32-1:0]   in_vector;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_index;
    logic [31:0]       out_value;
    logic              out_nan;

    int tests_run;
    int tests_failed;

    fp_argmax #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vector (in_vector),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_value (out_value),
        .out_nan   (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*32-1:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                              input logic [31:0] l2, input logic [31:0] l3);
        return {l0, l1, l2, l3};
    endfunction

    // Present one vector for a single accepting edge
    task automatic send(input logic [N*32-1:0] v);
        in_vector = v;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    // Edges from acceptance until out_valid; 0 if it never rises
    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drain;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run += 5;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1)  begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_index !== 2'd0) begin tests_failed++; $display("FAIL reset_out_index got %0d want 0", out_index); end
        if (out_value !== 32'h0) begin tests_failed++; $display("FAIL reset_out_value got %h want 0", out_value); end
        if (out_nan !== 1'b0)   begin tests_failed++; $display("FAIL reset_out_nan got %b want 0", out_nan); end
    endtask

    task automatic test_softmax;
        int lat;
        send(pack4(32'h3890969E, 32'h39D53C13, 32'h3D388CBF, 32'h3F745809));
        tests_run += 1;
        if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL softmax_in_ready_busy got %b want 0", in_ready); end
        wait_out(lat);
        tests_run += 4;
        if (lat !== 4) begin tests_failed++; $display("FAIL softmax_latency got %0d want 4", lat); end
        if (out_index !== 2'd3) begin tests_failed++; $display("FAIL softmax_index got %0d want 3", out_index); end
        if (out_value !== 32'h3F745809) begin tests_failed++; $display("FAIL softmax_value got %h want 3f745809", out_value); end
        if (out_nan !== 1'b0) begin tests_failed++; $display("FAIL softmax_nan got %b want 0", out_nan); end
        drain();
        tests_run += 2;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL softmax_release_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL softmax_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_signs_zero_tie;
        int lat;
        send(pack4(32'hC0000000, 32'h80000000, 32'h00000000, 32'hC0800000));
        wait_out(lat);
        tests_run += 4;
        if (lat !== 4) begin tests_failed++; $display("FAIL signs_latency got %0d want 4", lat); end
        if (out_index !== 2'd1) begin tests_failed++; $display("FAIL signs_index got %0d want 1", out_index); end
        if (out_value !== 32'h80000000) begin tests_failed++; $display("FAIL signs_value got %h want 80000000", out_value); end
        if (out_nan !== 1'b0) begin tests_failed++; $display("FAIL signs_nan got %b want 0", out_nan); end
        drain();
    endtask

    task automatic test_nan_inf;
        int lat;
        send(pack4(32'h7FC00000, 32'h3F800000, 32'h7F800000, 32'h40000000));
        wait_out(lat);
        tests_run += 4;
        if (lat !== 4) begin tests_failed++; $display("FAIL naninf_latency got %0d want 4", lat); end
        if (out_index !== 2'd2) begin tests_failed++; $display("FAIL naninf_index got %0d want 2", out_index); end
        if (out_value !== 32'h7F800000) begin tests_failed++; $display("FAIL naninf_value got %h want 7f800000", out_value); end
        if (out_nan !== 1'b0) begin tests_failed++; $display("FAIL naninf_nan got %b want 0", out_nan); end
        drain();
    endtask

    task automatic test_all_nan;
        int lat;
        send(pack4(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000));
        wait_out(lat);
        tests_run += 4;
        if (lat !== 4) begin tests_failed++; $display("FAIL allnan_latency got %0d want 4", lat); end
        if (out_index !== 2'd0) begin tests_failed++; $display("FAIL allnan_index got %0d want 0", out_index); end
        if (out_value !== 32'h7FC00000) begin tests_failed++; $display("FAIL allnan_value got %h want 7fc00000", out_value); end
        if (out_nan !== 1'b1) begin tests_failed++; $display("FAIL allnan_nan got %b want 1", out_nan); end
        drain();
    endtask

    // Lanes 3.0, 5.0, 5.0, 1.0: tie at 5.0 resolves to lane 1
    task automatic test_backpressure;
        int lat;
        send(pack4(32'h40400000, 32'h40A00000, 32'h40A00000, 32'h3F800000));
        wait_out(lat);
        tests_run += 1;
        if (lat !== 4) begin tests_failed++; $display("FAIL bp_latency got %0d want 4", lat); end
        in_vector = pack4(32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h7F800000);
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tests_run += 4;
            if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_c%0d got %b want 1", c, out_valid); end
            if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready_c%0d got %b want 0", c, in_ready); end
            if (out_index !== 2'd1) begin tests_failed++; $display("FAIL bp_index_c%0d got %0d want 1", c, out_index); end
            if (out_value !== 32'h40A00000) begin tests_failed++; $display("FAIL bp_value_c%0d got %h want 40a00000", c, out_value); end
        end
        in_valid = 1'b0;
        drain();
        tests_run += 2;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        // The vector offered during backpressure must not have started a scan
        @(posedge clk); #1;
        tests_run += 2;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_no_accept_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_no_accept_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_scan;
        int lat;
        send(pack4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run += 5;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        if (out_index !== 2'd0) begin tests_failed++; $display("FAIL midrst_index got %0d want 0", out_index); end
        if (out_value !== 32'h0) begin tests_failed++; $display("FAIL midrst_value got %h want 0", out_value); end
        if (out_nan !== 1'b0) begin tests_failed++; $display("FAIL midrst_nan got %b want 0", out_nan); end
        send(pack4(32'h3890969E, 32'h39D53C13, 32'h3D388CBF, 32'h3F745809));
        wait_out(lat);
        tests_run += 3;
        if (lat !== 4) begin tests_failed++; $display("FAIL midrst_latency got %0d want 4", lat); end
        if (out_index !== 2'd3) begin tests_failed++; $display("FAIL midrst_index2 got %0d want 3", out_index); end
        if (out_value !== 32'h3F745809) begin tests_failed++; $display("FAIL midrst_value2 got %h want 3f745809", out_value); end
        drain();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_vector    = '0;
        out_ready    = 1'b0;
        #1;
        test_reset();
        test_softmax();
        test_signs_zero_tie();
        test_nan_inf();
        test_all_nan();
        test_backpressure();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
